// File: rtl/ifc_pulse_decoder.sv
// ============================================================================
// Module   : ifc_pulse_decoder
// Brief    : IFC link pulse-width decoder; classifies high pulses (sync/0/1)
//            and assembles MSB-first frames from edge-detector strobes.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ifc_pulse_decoder #(
  parameter int FRAME_BITS = 16,
  parameter int CNT_W      = 8,
  parameter int BIT0_MIN   = 4,
  parameter int BIT1_MIN   = 12,
  parameter int SYNC_MIN   = 24,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pos_edge,
  input  logic                  neg_edge,
  output logic                  frame_valid,
  output logic [FRAME_BITS-1:0] frame_data,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int BC_W = $clog2(FRAME_BITS + 1);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_SYNC_HI = 2'd1;
  localparam logic [1:0] c_DATA_LO = 2'd2;
  localparam logic [1:0] c_DATA_HI = 2'd3;

  localparam logic [CNT_W-1:0] c_CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] c_BIT0     = CNT_W'(BIT0_MIN);
  localparam logic [CNT_W-1:0] c_BIT1     = CNT_W'(BIT1_MIN);
  localparam logic [CNT_W-1:0] c_SYNC     = CNT_W'(SYNC_MIN);
  localparam logic [CNT_W-1:0] c_TIMEOUT  = CNT_W'(TIMEOUT);
  localparam logic [BC_W-1:0]  c_FRAME    = BC_W'(FRAME_BITS);
  localparam logic [BC_W-1:0]  c_BC_ONE   = BC_W'(1);

  logic [1:0]            state_q,  state_d;
  logic [CNT_W-1:0]      cnt_q,    cnt_d;
  logic [FRAME_BITS-1:0] shift_q,  shift_d;
  logic [BC_W-1:0]       bitcnt_q, bitcnt_d;
  logic [FRAME_BITS-1:0] data_q,   data_d;
  logic                  valid_q,  valid_d;
  logic                  err_q,    err_d;

  // Coincident strobes cancel each other out.
  logic                  w_pe, w_ne;
  logic [CNT_W-1:0]      w_cnt_inc;
  logic                  w_timeout;
  logic                  w_is_glitch, w_is_sync, w_bit;
  logic [FRAME_BITS-1:0] w_shift_nxt;
  logic [BC_W-1:0]       w_bitcnt_inc;

  assign w_pe         = pos_edge & ~neg_edge;
  assign w_ne         = neg_edge & ~pos_edge;
  assign w_cnt_inc    = (cnt_q == c_CNT_MAX) ? cnt_q : cnt_q + c_CNT_ONE;
  assign w_timeout    = (cnt_q == c_TIMEOUT);
  assign w_is_glitch  = (cnt_q < c_BIT0);
  assign w_is_sync    = (cnt_q >= c_SYNC);
  assign w_bit        = (cnt_q >= c_BIT1);
  assign w_shift_nxt  = {shift_q[FRAME_BITS-2:0], w_bit};
  assign w_bitcnt_inc = bitcnt_q + c_BC_ONE;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      c_IDLE: begin
        if (w_pe) begin
          state_d = c_SYNC_HI;
          cnt_d   = c_CNT_ONE;
        end
      end
      c_SYNC_HI: begin
        cnt_d = w_cnt_inc;
        if (w_ne) begin
          if (w_is_sync) begin
            state_d  = c_DATA_LO;
            shift_d  = '0;
            bitcnt_d = '0;
            cnt_d    = c_CNT_ZERO;
          end else begin
            state_d = c_IDLE;
          end
        end else if (w_timeout) begin
          state_d = c_IDLE;
        end
      end
      c_DATA_LO: begin
        cnt_d = w_cnt_inc;
        if (w_pe) begin
          state_d = c_DATA_HI;
          cnt_d   = c_CNT_ONE;
        end else if (w_timeout) begin
          state_d = c_IDLE;
          err_d   = 1'b1;
        end
      end
      c_DATA_HI: begin
        cnt_d = w_cnt_inc;
        if (w_ne) begin
          if (w_is_glitch) begin
            state_d = c_IDLE;
            err_d   = 1'b1;
          end else if (w_is_sync) begin
            state_d  = c_DATA_LO;
            err_d    = 1'b1;
            shift_d  = '0;
            bitcnt_d = '0;
            cnt_d    = c_CNT_ZERO;
          end else begin
            shift_d  = w_shift_nxt;
            bitcnt_d = w_bitcnt_inc;
            cnt_d    = c_CNT_ZERO;
            if (w_bitcnt_inc == c_FRAME) begin
              state_d = c_IDLE;
              data_d  = w_shift_nxt;
              valid_d = 1'b1;
            end else begin
              state_d = c_DATA_LO;
            end
          end
        end else if (w_timeout) begin
          state_d = c_IDLE;
          err_d   = 1'b1;
        end
      end
      default: state_d = c_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= c_IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      bitcnt_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign frame_valid = valid_q;
  assign frame_data  = data_q;
  assign frame_err   = err_q;
  assign busy        = (state_q != c_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ifc_pulse_decoder.sv
// ============================================================================
// Module   : tb_ifc_pulse_decoder
// Brief    : Scoreboard bench for ifc_pulse_decoder with FRAME_BITS=8.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ifc_pulse_decoder;

  localparam int TIMEOUT = 64;

  logic       clk;
  logic       rst_n;
  logic       pos_edge;
  logic       neg_edge;
  logic       frame_valid;
  logic [7:0] frame_data;
  logic       frame_err;
  logic       busy;

  int checks, errors;
  int cyc, neg_cyc, valid_cyc, err_cyc, sync_neg;
  int n_valid, n_err;
  logic err_busy;
  logic [7:0] exp_q[$];
  logic [7:0] exp_d;

  ifc_pulse_decoder #(
    .FRAME_BITS(8), .CNT_W(8), .BIT0_MIN(4), .BIT1_MIN(12), .SYNC_MIN(24), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pos_edge(pos_edge), .neg_edge(neg_edge),
    .frame_valid(frame_valid), .frame_data(frame_data), .frame_err(frame_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Caller must be at a negedge; returns at a negedge.
  task automatic send_pulse(input int hi, input int lo);
    pos_edge = 1'b1;
    @(negedge clk) pos_edge = 1'b0;
    repeat (hi - 1) @(negedge clk);
    neg_edge = 1'b1;
    @(negedge clk) neg_edge = 1'b0;
    repeat (lo - 1) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input int lo);
    send_pulse(b ? 16 : 6, lo);
  endtask

  task automatic send_frame(input logic [7:0] d, input int last_lo);
    send_pulse(30, 8);
    sync_neg = neg_cyc;
    for (int i = 7; i >= 0; i--) begin
      if (i == 0) exp_q.push_back(d);
      send_bit(d[i], (i == 0) ? last_lo : 8);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: busy=%b after 300 cycles, required 0", busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pos_edge = 1'b0; neg_edge = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({frame_valid, frame_err, busy, frame_data} !== 11'd0) begin
      errors++;
      $display("FAIL reset_state: valid=%b err=%b busy=%b data=%h, required all 0",
               frame_valid, frame_err, busy, frame_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_glitch();
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    send_pulse(30, 8);
    send_bit(1'b1, 8); send_bit(1'b0, 8); send_bit(1'b1, 8);
    send_pulse(2, 8);
    checks++;
    if (n_err - e0 != 1) begin errors++; $display("FAIL glitch_err_count: got %0d required 1", n_err - e0); end
    checks++;
    if (err_cyc != neg_cyc) begin errors++; $display("FAIL glitch_err_latency: err at %0d required %0d", err_cyc, neg_cyc); end
    checks++;
    if (n_valid != v0) begin errors++; $display("FAIL glitch_no_valid: got %0d valids required 0", n_valid - v0); end
    checks++;
    if (frame_data !== 8'h00) begin errors++; $display("FAIL glitch_data_hold: got %h required 00", frame_data); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL glitch_idle: busy=%b required 0", busy); end
  endtask

  task automatic test_frame(input logic [7:0] d);
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    send_frame(d, 8);
    wait_idle();
    checks++;
    if (n_valid - v0 != 1) begin errors++; $display("FAIL frame_%h_valid_count: got %0d required 1", d, n_valid - v0); end
    checks++;
    if (n_err != e0) begin errors++; $display("FAIL frame_%h_no_err: got %0d errs required 0", d, n_err - e0); end
    checks++;
    if (valid_cyc != neg_cyc) begin errors++; $display("FAIL frame_%h_latency: valid at %0d required %0d", d, valid_cyc, neg_cyc); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL frame_%h_scoreboard: %0d frames outstanding required 0", d, exp_q.size()); end
  endtask

  task automatic test_timeout();
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    send_pulse(30, 8);
    send_bit(1'b0, 8); send_bit(1'b1, 8); send_bit(1'b1, 1);
    for (int i = 0; i < 120; i++) begin
      if (n_err != e0) break;
      @(negedge clk);
    end
    checks++;
    if (n_err - e0 != 1) begin errors++; $display("FAIL timeout_err_count: got %0d required 1", n_err - e0); end
    // cnt loads 0 on the neg cycle, equals TIMEOUT 64 cycles later, error registered one cycle after.
    checks++;
    if (err_cyc != neg_cyc + TIMEOUT + 1) begin
      errors++; $display("FAIL timeout_latency: err at %0d required %0d", err_cyc, neg_cyc + TIMEOUT + 1);
    end
    checks++;
    if (err_busy !== 1'b0) begin errors++; $display("FAIL timeout_busy: busy=%b with err, required 0", err_busy); end
    checks++;
    if (n_valid != v0) begin errors++; $display("FAIL timeout_no_valid: got %0d required 0", n_valid - v0); end
  endtask

  task automatic test_resync();
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    send_pulse(30, 8);
    send_bit(1'b1, 8); send_bit(1'b1, 8); send_bit(1'b0, 8); send_bit(1'b0, 8);
    send_frame(8'h3C, 8);
    wait_idle();
    checks++;
    if (n_err - e0 != 1) begin errors++; $display("FAIL resync_err_count: got %0d required 1", n_err - e0); end
    checks++;
    if (err_cyc != sync_neg) begin errors++; $display("FAIL resync_err_time: err at %0d required %0d", err_cyc, sync_neg); end
    checks++;
    if (n_valid - v0 != 1) begin errors++; $display("FAIL resync_valid_count: got %0d required 1", n_valid - v0); end
    checks++;
    if (frame_data !== 8'h3C) begin errors++; $display("FAIL resync_data: got %h required 3c", frame_data); end
  endtask

  task automatic test_widths();
    int w[8];
    int v0;
    w = '{4, 11, 12, 23, 4, 12, 11, 23};
    v0 = n_valid;
    send_pulse(24, 8);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) exp_q.push_back(8'h35);
      send_pulse(w[i], 8);
    end
    wait_idle();
    checks++;
    if (n_valid - v0 != 1) begin errors++; $display("FAIL widths_valid_count: got %0d required 1", n_valid - v0); end
  endtask

  task automatic test_reset_midframe();
    int v0, e0;
    send_pulse(30, 8);
    send_bit(1'b0, 8); send_bit(1'b1, 8); send_bit(1'b0, 8); send_bit(1'b1, 8);
    pos_edge = 1'b1;
    @(negedge clk) pos_edge = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL midframe_busy: busy=%b required 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({frame_valid, frame_err, busy, frame_data} !== 11'd0) begin
      errors++;
      $display("FAIL async_reset: valid=%b err=%b busy=%b data=%h, required all 0",
               frame_valid, frame_err, busy, frame_data);
    end
    @(negedge clk) rst_n = 1'b1;
    v0 = n_valid; e0 = n_err;
    send_frame(8'h5A, 8);
    wait_idle();
    checks++;
    if (n_valid - v0 != 1 || n_err != e0) begin
      errors++; $display("FAIL after_reset: valids=%0d errs=%0d required 1 and 0", n_valid - v0, n_err - e0);
    end
  endtask

  task automatic test_idle_pulse();
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    pos_edge = 1'b1;
    @(negedge clk) pos_edge = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL idle_pulse_start: busy=%b required 1", busy); end
    repeat (15) @(negedge clk);
    neg_edge = 1'b1;
    @(negedge clk) neg_edge = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_pulse_end: busy=%b required 0", busy); end
    repeat (4) @(negedge clk);
    pos_edge = 1'b1; neg_edge = 1'b1;
    @(negedge clk) begin pos_edge = 1'b0; neg_edge = 1'b0; end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL simultaneous_edges: busy=%b required 0", busy); end
    repeat (5) @(negedge clk);
    checks++;
    if (n_valid != v0 || n_err != e0) begin
      errors++; $display("FAIL idle_pulse_strobes: valids=%0d errs=%0d required 0 and 0", n_valid - v0, n_err - e0);
    end
  endtask

  task automatic test_back_to_back();
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    send_frame(8'hC3, 1);
    send_frame(8'h81, 8);
    wait_idle();
    checks++;
    if (n_valid - v0 != 2 || n_err != e0) begin
      errors++; $display("FAIL back_to_back: valids=%0d errs=%0d required 2 and 0", n_valid - v0, n_err - e0);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL back_to_back_scoreboard: %0d outstanding required 0", exp_q.size()); end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; neg_cyc = 0; valid_cyc = 0; err_cyc = 0;
    sync_neg = 0; n_valid = 0; n_err = 0; err_busy = 1'b0;
    rst_n = 1'b0; pos_edge = 1'b0; neg_edge = 1'b0;
    fork
      // Monitor: cyc labels the edge after which outputs are observed.
      forever begin
        @(posedge clk);
        cyc++;
        if (neg_edge && !pos_edge) neg_cyc = cyc;
        #1;
        if (frame_valid === 1'b1) begin
          n_valid++;
          valid_cyc = cyc;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL frame_unexpected: got frame_data=%h, no frame expected", frame_data);
          end else begin
            exp_d = exp_q.pop_front();
            if (frame_data !== exp_d) begin
              errors++;
              $display("FAIL frame_data: got %h required %h", frame_data, exp_d);
            end
          end
          checks++;
          if (frame_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL valid_exclusive: err=%b busy=%b with valid, required 0 0", frame_err, busy);
          end
        end
        if (frame_err === 1'b1) begin
          n_err++;
          err_cyc = cyc;
          err_busy = busy;
        end
      end
      begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog expired");
      end
    join_none

    test_reset();
    test_glitch();
    test_frame(8'hA5);
    test_timeout();
    test_resync();
    test_widths();
    test_reset_midframe();
    test_idle_pulse();
    test_back_to_back();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
